posit_encoder: RTL and testbench

//  Packs decoded posit fields (sign, regime, exponent, mantissa) into a WIDTH-bit posit word.

---
 rtl/posit_encoder.sv | 144 ++++++++++++++
 tb/tb_posit_encoder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/posit_encoder.sv
// Packs decoded posit fields (sign, regime k, exponent, fraction) into a WIDTH-bit posit,
// rounding to nearest-even and clamping to maxpos/minpos, over three pipeline stages.
module posit_encoder #(
  parameter int WIDTH = 7,
  parameter int EN    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic             in_zero,
  input  logic             in_nar,
  input  logic [7:0]       in_regime,
  input  logic [7:0]       in_exp,
  input  logic [7:0]       in_mant,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q
);

  localparam int N  = WIDTH;
  localparam int TW = EN + 8;
  localparam int BW = N + EN + 8;
  localparam logic [N-2:0] MAG_MAX = '1;
  localparam logic [N-2:0] MAG_MIN = (N-1)'(1);
  localparam logic [N-1:0] NAR_WORD = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] ONE_WORD = N'(1);

  // Handshake: a stage takes new data when it is empty or its contents move on this
  // cycle; in_ready = ~v1 | load2, and the output holds while out_valid & ~out_ready.
  logic v1, v2, v3;
  logic load1, load2, load3;

  assign load3     = ~v3 | out_ready;
  assign load2     = ~v2 | load3;
  assign load1     = ~v1 | load2;
  assign in_ready  = load1;
  assign out_valid = v3;

  // Stage 1: regime run, terminator, exponent and fraction laid out MSB-first.
  logic [TW-1:0] tail;
  logic          unused_exp;

  if (EN > 0) begin : g_exp
    assign tail       = {in_exp[EN-1:0], in_mant};
    assign unused_exp = ^in_exp[7:EN];
  end else begin : g_noexp
    assign tail       = in_mant;
    assign unused_exp = ^in_exp;
  end

  logic          run_bit;
  logic [7:0]    run_len;
  logic [BW-1:0] seed;
  logic [BW-1:0] shaped;
  logic          sat_hi, sat_lo;

  // The run is shifted in from the top: k >= 0 gives k+1 ones, k < 0 gives -k zeros.
  assign run_bit = ~in_regime[7];
  assign run_len = run_bit ? (in_regime + 8'd1) : (8'd0 - in_regime);
  assign seed    = {~run_bit, tail, {(BW-1-TW){1'b0}}};
  assign shaped  = (seed >> run_len) | (run_bit ? ~({BW{1'b1}} >> run_len) : '0);
  assign sat_hi  = int'($signed(in_regime)) >= (N - 2);
  assign sat_lo  = int'($signed(in_regime)) <= -(N - 1);

  logic [N-2:0] s1_body;
  logic         s1_guard, s1_sticky, s1_sign, s1_zero, s1_nar, s1_sat_hi, s1_sat_lo;

  // Stage 2: round to nearest-even, then clamp into [minpos, maxpos].
  logic         inc;
  logic [N-1:0] sum;
  logic [N-2:0] mag;

  assign inc = s1_guard & (s1_sticky | s1_body[0]);
  assign sum = {1'b0, s1_body} + {{(N-1){1'b0}}, inc};

  always_comb begin
    mag = sum[N-2:0];
    if (s1_sat_lo) begin
      mag = MAG_MIN;
    end else if (s1_sat_hi || sum[N-1]) begin
      mag = MAG_MAX;
    end else if (sum[N-2:0] == '0) begin
      mag = MAG_MIN;
    end
  end

  logic [N-2:0] s2_mag;
  logic         s2_sign, s2_zero, s2_nar;

  // Stage 3: special values, then negate the magnitude for negative inputs.
  logic [N-1:0] word;
  logic [N-1:0] q_next;

  assign word = {1'b0, s2_mag};

  always_comb begin
    q_next = word;
    if (s2_nar) begin
      q_next = NAR_WORD;
    end else if (s2_zero) begin
      q_next = '0;
    end else if (s2_sign) begin
      q_next = ~word + ONE_WORD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      q  <= '0;
    end else begin
      if (load1) v1 <= in_valid;
      if (load2) v2 <= v1;
      if (load3) begin
        v3 <= v2;
        if (v2) q <= q_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load1 && in_valid) begin
      s1_body   <= shaped[BW-1 -: N-1];
      s1_guard  <= shaped[BW-N];
      s1_sticky <= |shaped[BW-N-1:0];
      s1_sign   <= in_sign;
      s1_zero   <= in_zero;
      s1_nar    <= in_nar;
      s1_sat_hi <= sat_hi;
      s1_sat_lo <= sat_lo;
    end
    if (load2 && v1) begin
      s2_mag  <= mag;
      s2_sign <= s1_sign;
      s2_zero <= s1_zero;
      s2_nar  <= s1_nar;
    end
  end

endmodule

// File: tb/tb_posit_encoder.sv
// Directed bench for posit_encoder (WIDTH=7, EN=1): vector table plus handshake,
// back-pressure and mid-stream reset sequences.
module tb_posit_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid, in_ready, in_sign, in_zero, in_nar;
  logic [7:0] in_regime, in_exp, in_mant;
  logic       out_valid, out_ready;
  logic [6:0] q;

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] exp_q[$];

  typedef struct {
    logic       sign;
    logic       zero;
    logic       nar;
    logic [7:0] k;
    logic [7:0] e;
    logic [7:0] m;
    logic [6:0] want;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  posit_encoder #(.WIDTH(7), .EN(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_zero(in_zero), .in_nar(in_nar),
    .in_regime(in_regime), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready),
    .q(q)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic drive_fields(input vec_t v);
    in_sign   = v.sign;
    in_zero   = v.zero;
    in_nar    = v.nar;
    in_regime = v.k;
    in_exp    = v.e;
    in_mant   = v.m;
  endtask

  // Called at posedge+1; returns at posedge+1 once the result is visible.
  task automatic send_one(input vec_t v, input string name);
    int cycles;
    drive_fields(v);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check({name, "_in_ready"}, 16'(in_ready), 16'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cycles = 1;
    while (!out_valid && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    check({name, "_latency"}, 16'(cycles), 16'd3);
    check({name, "_q"}, 16'(q), 16'(v.want));
  endtask

  initial begin
    // sign zero nar  k      exp    mant   q
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 8'd0,   8'd0,   8'h00, 7'h20};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'd0,   8'd0,   8'h00, 7'h60};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'd0,   8'd1,   8'h00, 7'h28};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'd1,   8'd0,   8'h00, 7'h30};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'd5,   8'd0,   8'h00, 7'h3F};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'd7,   8'd0,   8'hFF, 7'h3F};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'd0,   8'd0,   8'h10, 7'h20};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'd0,   8'd0,   8'h30, 7'h22};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'd0,   8'd0,   8'h11, 7'h21};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'd0,   8'd0,   8'hF0, 7'h28};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 8'hFB,  8'd0,   8'h00, 7'h01};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 8'hF7,  8'd0,   8'h00, 7'h01};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 8'd3,   8'd1,   8'h55, 7'h00};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 8'd2,   8'd0,   8'hAA, 7'h40};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 8'hFF,  8'd0,   8'h00, 7'h10};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 8'hFF,  8'd0,   8'h00, 7'h70};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 8'd4,   8'd1,   8'h00, 7'h3E};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 8'd4,   8'd1,   8'h80, 7'h3F};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 8'd0,   8'hFE,  8'h00, 7'h20};

    in_valid = 1'b0; out_ready = 1'b0;
    drive_fields(vecs[0]);

    // Reset state
    #1 rst = 1'b1;
    #2;
    check("reset_out_valid", 16'(out_valid), 16'd0);
    check("reset_q", 16'(q), 16'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_in_ready", 16'(in_ready), 16'd1);

    // Vector table, one transaction at a time
    for (int i = 0; i < NV; i++) begin
      send_one(vecs[i], $sformatf("vec%0d", i));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Back-to-back stream with out_ready toggling
    begin
      int   idx, got, cyc;
      logic prev_stall;
      logic [6:0] prev_q, want;
      idx = 0; got = 0; cyc = 0; prev_stall = 1'b0; prev_q = '0;
      while (got < 8 && cyc < 100) begin
        out_ready = cyc[0];
        in_valid  = (idx < 8);
        if (idx < 8) drive_fields(vecs[idx]);
        #1;
        if (prev_stall) begin
          check("stall_valid", 16'(out_valid), 16'd1);
          check("stall_q", 16'(q), 16'(prev_q));
        end
        if (!in_ready) begin
          check("in_ready_low_only_when_full", 16'({out_valid, out_ready}), 16'b10);
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(vecs[idx].want);
          idx++;
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("stream_unexpected_output", 16'(q), 16'hFFFF);
          end else begin
            want = exp_q.pop_front();
            check($sformatf("stream_out%0d", got), 16'(q), 16'(want));
          end
          got++;
        end
        prev_stall = out_valid && !out_ready;
        prev_q     = q;
        @(posedge clk); #1;
        cyc++;
      end
      in_valid = 1'b0;
      check("stream_count", 16'(got), 16'd8);
      out_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
        #1;
        check("stream_no_duplicate", 16'(out_valid), 16'd0);
        @(posedge clk); #1;
      end
    end

    // Mid-stream asynchronous reset with three results in flight
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      drive_fields(vecs[j]);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("inflight_out_valid", 16'(out_valid), 16'd1);
    check("inflight_q", 16'(q), 16'h20);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out_valid", 16'(out_valid), 16'd0);
    check("async_rst_q", 16'(q), 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    send_one(vecs[3], "post_reset");
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int j = 0; j < 3; j++) begin
      check("post_reset_no_stale", 16'(out_valid), 16'd0);
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
